// File: rtl/pong_pkg.sv
// Shared types and default geometry for the Pong game-state path.
// The FSM state type lives here so the bench and any box-drawing stage
// can decode the exported state. The DEF_* constants are the defaults
// for the motion engine parameters and for the box instances.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_PADDLE_W    = 10;
  localparam int DEF_PADDLE_H    = 50;
  localparam int DEF_BALL_SIZE   = 8;
  localparam int DEF_P1_X        = 0;
  localparam int DEF_P2_X        = 630;
  localparam int DEF_PADDLE_STEP = 2;
  localparam int DEF_BALL_SPEED  = 1;
  localparam int DEF_HOLD_FRAMES = 60;
  localparam int DEF_WIN_SCORE   = 9;

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle's vertical position, updated once per frame tick.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   tick       : one-cycle frame strobe; nothing changes without it
//   enable     : paddle may move on this tick
//   centre     : recentre the paddle on this tick (wins over movement)
//   up, down   : level-sensitive buttons; both or neither means hold
//   y          : paddle top edge, always within [0, SCREEN_H-PADDLE_H]
module pong_paddle_ctrl #(
  parameter int PADDLE_STEP = 2,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       centre,
  input  logic       up,
  input  logic       down,
  output logic [9:0] y
);

  localparam logic [10:0] STEP     = 11'(PADDLE_STEP);
  localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]  Y_CENTRE = 10'((SCREEN_H - PADDLE_H) / 2);

  logic [10:0] y_ext;
  logic [9:0]  y_up;
  logic [9:0]  y_dn;

  // 11-bit math with explicit clamps so the paddle can never wrap.
  always_comb begin
    y_ext = {1'b0, y};
    y_up  = (y_ext < STEP) ? 10'd0 : 10'(y_ext - STEP);
    y_dn  = (y_ext + STEP > Y_MAX) ? 10'(Y_MAX) : 10'(y_ext + STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= Y_CENTRE;
    end else if (tick) begin
      if (centre) begin
        y <= Y_CENTRE;
      end else if (enable) begin
        if (up && !down)      y <= y_up;
        else if (down && !up) y <= y_dn;
      end
    end
  end

endmodule

// File: rtl/pong_motion_engine.sv
// Pong game-state writer: ball, paddles, direction, scores, rally FSM.
// Advances once per frame on the falling edge of v_visible and presents
// registered box coordinates to the drawing stage.
// Ports:
//   CLOCK_50, RESET_N          : clock, asynchronous active-low reset
//   v_visible                  : VGA vertical-visible flag (same clock)
//   p1_up/p1_down/p2_up/p2_down: paddle buttons, level-sensitive
//   serve                      : serve / restart request
//   ball_x, ball_y             : ball top-left corner
//   p1_y, p2_y                 : paddle top edges
//   score_p1, score_p2         : scores, saturating at WIN_SCORE
//   game_over                  : high in OVER
//   state_dbg                  : current FSM state for observation
module pong_motion_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int PADDLE_W    = DEF_PADDLE_W,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int P1_X        = DEF_P1_X,
  parameter int P2_X        = DEF_P2_X,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP,
  parameter int BALL_SPEED  = DEF_BALL_SPEED,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int WIN_SCORE   = DEF_WIN_SCORE
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        v_visible,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic        serve,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [9:0]  p1_y,
  output logic [9:0]  p2_y,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        game_over,
  output game_state_t state_dbg
);

  localparam logic [10:0] SPD     = 11'(BALL_SPEED);
  localparam logic [10:0] BSZ     = 11'(BALL_SIZE);
  localparam logic [10:0] PH      = 11'(PADDLE_H);
  localparam logic [10:0] Y_LIM   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] X_LIM   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] P1_FACE = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] P2_XL   = 11'(P2_X);
  localparam logic [10:0] P2_FACE = 11'(P2_X - BALL_SIZE);
  localparam logic [9:0]  X0      = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  Y0      = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
  localparam int          HOLD_W  = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  game_state_t       state_q, state_d;
  logic              v_vis_q, tick;
  logic              serve_pending;
  logic              dx_neg, dy_neg;   // 1 = moving left / up
  logic              p2_scored;        // who took the last point
  logic [HOLD_W-1:0] hold_cnt;
  logic              paddle_en, paddle_centre;

  logic [10:0] bx, by, p1e, p2e;
  logic [9:0]  nx, ny;
  logic        ndx_neg, ndy_neg, p1_hit, p2_hit, miss_left, miss_right;

  // Frame strobe: one cycle after v_visible falls.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) v_vis_q <= 1'b0;
    else          v_vis_q <= v_visible;
  end
  always_comb tick = v_vis_q & ~v_visible;

  // Ball step for PLAY. Vertical first, then the horizontal side checks;
  // wall and paddle bounces on the same tick both take effect. Overlap
  // tests use the positions held before this tick.
  always_comb begin
    bx = {1'b0, ball_x};
    by = {1'b0, ball_y};
    p1e = {1'b0, p1_y};
    p2e = {1'b0, p2_y};
    p1_hit = (by + BSZ > p1e) && (by < p1e + PH);
    p2_hit = (by + BSZ > p2e) && (by < p2e + PH);
    ny = ball_y;
    nx = ball_x;
    ndy_neg = dy_neg;
    ndx_neg = dx_neg;
    miss_left = 1'b0;
    miss_right = 1'b0;
    if (dy_neg && by < SPD) begin
      ny = 10'd0;
      ndy_neg = 1'b0;
    end else if (!dy_neg && by + SPD > Y_LIM) begin
      ny = 10'(Y_LIM);
      ndy_neg = 1'b1;
    end else if (dy_neg) begin
      ny = 10'(by - SPD);
    end else begin
      ny = 10'(by + SPD);
    end
    if (dx_neg) begin
      if (bx < P1_FACE + SPD && p1_hit) begin
        nx = 10'(P1_FACE);
        ndx_neg = 1'b0;
      end else if (bx < SPD) begin
        nx = 10'd0;
        miss_left = 1'b1;
      end else begin
        nx = 10'(bx - SPD);
      end
    end else begin
      if (bx + BSZ + SPD > P2_XL && p2_hit) begin
        nx = 10'(P2_FACE);
        ndx_neg = 1'b1;
      end else if (bx + SPD > X_LIM) begin
        nx = 10'(X_LIM);
        miss_right = 1'b1;
      end else begin
        nx = 10'(bx + SPD);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state (only moves on a tick)
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        IDLE:    if (serve_pending) state_d = PLAY;
        PLAY:    if (miss_left || miss_right) state_d = POINT;
        POINT:   if (hold_cnt == HOLD_LAST)
                   state_d = (score_p1 == WIN || score_p2 == WIN) ? OVER : IDLE;
        OVER:    if (serve_pending) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    game_over     = (state_q == OVER);
    paddle_en     = (state_q != OVER);
    paddle_centre = (state_q == OVER) && serve_pending;
    state_dbg     = state_q;
  end

  // Serve requests are only latched while waiting for one; POINT and
  // PLAY ignore the button.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      serve_pending <= 1'b0;
    end else if (state_q == IDLE || state_q == OVER) begin
      if (tick && serve_pending) serve_pending <= 1'b0;
      else if (serve)            serve_pending <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ball_x    <= X0;
      ball_y    <= Y0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
      p2_scored <= 1'b0;
      hold_cnt  <= '0;
    end else if (tick) begin
      case (state_q)
        PLAY: begin
          ball_x   <= nx;
          ball_y   <= ny;
          dx_neg   <= ndx_neg;
          dy_neg   <= ndy_neg;
          hold_cnt <= '0;
          if (miss_left) begin
            p2_scored <= 1'b1;
            if (score_p2 < WIN) score_p2 <= score_p2 + 4'd1;
          end
          if (miss_right) begin
            p2_scored <= 1'b0;
            if (score_p1 < WIN) score_p1 <= score_p1 + 4'd1;
          end
        end
        POINT: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (state_d == IDLE) begin
              // Next rally heads toward the player who conceded.
              ball_x <= X0;
              ball_y <= Y0;
              dx_neg <= p2_scored;
              dy_neg <= ~dy_neg;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        OVER: begin
          if (serve_pending) begin
            score_p1 <= 4'd0;
            score_p2 <= 4'd0;
            ball_x   <= X0;
            ball_y   <= Y0;
          end
        end
        default: begin
          ball_x <= X0;
          ball_y <= Y0;
        end
      endcase
    end
  end

  pong_paddle_ctrl #(
    .PADDLE_STEP(PADDLE_STEP), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H)
  ) u_p1 (
    .clk(CLOCK_50), .rst_n(RESET_N), .tick(tick), .enable(paddle_en),
    .centre(paddle_centre), .up(p1_up), .down(p1_down), .y(p1_y)
  );

  pong_paddle_ctrl #(
    .PADDLE_STEP(PADDLE_STEP), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H)
  ) u_p2 (
    .clk(CLOCK_50), .rst_n(RESET_N), .tick(tick), .enable(paddle_en),
    .centre(paddle_centre), .up(p2_up), .down(p2_down), .y(p2_y)
  );

endmodule

// File: tb/tb_pong_motion_engine.sv
// Directed bench for pong_motion_engine. Each frame is 2 cycles of
// v_visible high then 2 low; outputs are sampled on the falling clock edge.
module tb_pong_motion_engine;
  import pong_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        v_visible = 1'b0;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic        serve = 1'b0;
  logic [9:0]  ball_x, ball_y, p1_y, p2_y;
  logic [3:0]  score_p1, score_p2;
  logic        game_over;
  game_state_t state_dbg;

  int checks = 0;
  int passes = 0;

  pong_motion_engine dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .v_visible(v_visible),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .serve(serve), .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, checks=%0d passes=%0d", checks, passes);
    $fatal(1);
  end

  task automatic do_reset();
    {p1_up, p1_down, p2_up, p2_down, serve, v_visible} = '0;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
  endtask

  // drivers
  task automatic frame();
    v_visible = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    v_visible = 1'b0;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_serve();
    serve = 1'b1;
    @(negedge CLOCK_50);
    serve = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) $display("FAIL reset_ball got %0d,%0d want 316,236", ball_x, ball_y); else passes++;
    checks++; if (p1_y !== 10'd215 || p2_y !== 10'd215) $display("FAIL reset_paddles got %0d,%0d want 215,215", p1_y, p2_y); else passes++;
    checks++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || game_over !== 1'b0 || state_dbg !== IDLE)
      $display("FAIL reset_state got s=%0d,%0d go=%0d st=%0d want 0,0,0,0", score_p1, score_p2, game_over, state_dbg); else passes++;
    pulse_serve();
    frame();
    frames(84);
    checks++; if (ball_x !== 10'd400 || ball_y !== 10'd320 || state_dbg !== PLAY)
      $display("FAIL play_84 got %0d,%0d st=%0d want 400,320 st=1", ball_x, ball_y, state_dbg); else passes++;
    // asynchronous reset between clock edges
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236 || p1_y !== 10'd215 || p2_y !== 10'd215)
      $display("FAIL async_reset_pos got %0d,%0d p=%0d,%0d want 316,236 p=215,215", ball_x, ball_y, p1_y, p2_y); else passes++;
    checks++; if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || game_over !== 1'b0 || state_dbg !== IDLE)
      $display("FAIL async_reset_state got s=%0d,%0d go=%0d st=%0d want 0,0,0,0", score_p1, score_p2, game_over, state_dbg); else passes++;
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_paddle_clamp();
    int e;
    do_reset();
    p1_down = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      frame();
      e = (215 + 2 * i > 430) ? 430 : 215 + 2 * i;
      checks++; if (p1_y !== 10'(e)) $display("FAIL p1_down_step%0d got %0d want %0d", i, p1_y, e); else passes++;
    end
    p1_up = 1'b1;
    frames(5);
    checks++; if (p1_y !== 10'd430 || p2_y !== 10'd215) $display("FAIL both_held got %0d,%0d want 430,215", p1_y, p2_y); else passes++;
    p1_down = 1'b0;
    p2_up = 1'b1;
    frames(107);
    checks++; if (p1_y !== 10'd216 || p2_y !== 10'd1) $display("FAIL up_107 got %0d,%0d want 216,1", p1_y, p2_y); else passes++;
    frame();
    checks++; if (p2_y !== 10'd0 || p1_y !== 10'd214) $display("FAIL p2_one_to_zero got %0d,%0d want 0,214", p2_y, p1_y); else passes++;
    frames(107);
    checks++; if (p1_y !== 10'd0 || p2_y !== 10'd0) $display("FAIL up_floor got %0d,%0d want 0,0", p1_y, p2_y); else passes++;
    frames(3);
    checks++; if (p1_y !== 10'd0 || p2_y !== 10'd0) $display("FAIL up_no_wrap got %0d,%0d want 0,0", p1_y, p2_y); else passes++;
    p1_up = 1'b0;
    p2_up = 1'b0;
  endtask

  task automatic test_serve_and_tick();
    do_reset();
    pulse_serve();
    checks++; if (state_dbg !== IDLE) $display("FAIL serve_waits_tick got st=%0d want 0", state_dbg); else passes++;
    frame();
    checks++; if (state_dbg !== PLAY || ball_x !== 10'd316 || ball_y !== 10'd236)
      $display("FAIL serve_enter got st=%0d %0d,%0d want 1 316,236", state_dbg, ball_x, ball_y); else passes++;
    // long low period: one move at the falling edge, none afterwards
    v_visible = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    v_visible = 1'b0;
    @(negedge CLOCK_50);
    checks++; if (ball_x !== 10'd317 || ball_y !== 10'd237) $display("FAIL first_move got %0d,%0d want 317,237", ball_x, ball_y); else passes++;
    repeat (5) @(negedge CLOCK_50);
    v_visible = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    checks++; if (ball_x !== 10'd317 || ball_y !== 10'd237) $display("FAIL hold_between_ticks got %0d,%0d want 317,237", ball_x, ball_y); else passes++;
    v_visible = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (ball_x !== 10'd318 || ball_y !== 10'd238) $display("FAIL second_move got %0d,%0d want 318,238", ball_x, ball_y); else passes++;
  endtask

  // continues the rally from test_serve_and_tick (ball at 318,238)
  task automatic test_wall_and_right_miss();
    frames(233);
    checks++; if (ball_x !== 10'd551 || ball_y !== 10'd471) $display("FAIL pre_wall got %0d,%0d want 551,471", ball_x, ball_y); else passes++;
    frame();
    checks++; if (ball_x !== 10'd552 || ball_y !== 10'd472) $display("FAIL at_wall got %0d,%0d want 552,472", ball_x, ball_y); else passes++;
    frames(3);
    checks++; if (ball_y >= 10'd472 || ball_y < 10'd469) $display("FAIL wall_bounce got y=%0d want 469..471", ball_y); else passes++;
    frames(77);
    checks++; if (ball_x !== 10'd632 || ball_y !== 10'd393 || state_dbg !== PLAY)
      $display("FAIL right_edge got %0d,%0d st=%0d want 632,393 st=1", ball_x, ball_y, state_dbg); else passes++;
    frame();
    checks++; if (state_dbg !== POINT || score_p1 !== 4'd1 || score_p2 !== 4'd0 || ball_x !== 10'd632 || ball_y !== 10'd392)
      $display("FAIL right_miss got st=%0d s=%0d,%0d %0d,%0d want 2 s=1,0 632,392", state_dbg, score_p1, score_p2, ball_x, ball_y); else passes++;
  endtask

  // continues in POINT after the right miss
  task automatic test_point_hold();
    pulse_serve();
    p1_down = 1'b1;
    frames(59);
    p1_down = 1'b0;
    checks++; if (state_dbg !== POINT || ball_x !== 10'd632 || ball_y !== 10'd392 || p1_y !== 10'd333)
      $display("FAIL point_hold got st=%0d %0d,%0d p1=%0d want 2 632,392 p1=333", state_dbg, ball_x, ball_y, p1_y); else passes++;
    frame();
    checks++; if (state_dbg !== IDLE || ball_x !== 10'd316 || ball_y !== 10'd236 || score_p1 !== 4'd1)
      $display("FAIL point_exit got st=%0d %0d,%0d s1=%0d want 0 316,236 s1=1", state_dbg, ball_x, ball_y, score_p1); else passes++;
    frame();
    checks++; if (state_dbg !== IDLE) $display("FAIL serve_ignored_in_point got st=%0d want 0", state_dbg); else passes++;
    pulse_serve();
    frames(2);
    checks++; if (ball_x !== 10'd317 || ball_y !== 10'd237) $display("FAIL serve_dir_after_p1 got %0d,%0d want 317,237", ball_x, ball_y); else passes++;
  endtask

  task automatic test_left_hit();
    do_reset();
    p2_down = 1'b1;
    frames(88);
    p2_down = 1'b0;
    checks++; if (p2_y !== 10'd391 || p1_y !== 10'd215) $display("FAIL hit_setup got %0d,%0d want 215,391", p1_y, p2_y); else passes++;
    pulse_serve();
    frame();
    frames(307);
    checks++; if (ball_x !== 10'd622 || ball_y !== 10'd402) $display("FAIL right_hit got %0d,%0d want 622,402", ball_x, ball_y); else passes++;
    frame();
    checks++; if (ball_x !== 10'd621 || ball_y !== 10'd401) $display("FAIL after_right_hit got %0d,%0d want 621,401", ball_x, ball_y); else passes++;
    frames(611);
    checks++; if (ball_x !== 10'd10 || ball_y !== 10'd209) $display("FAIL pre_left_hit got %0d,%0d want 10,209", ball_x, ball_y); else passes++;
    frame();
    checks++; if (ball_x !== 10'd10 || ball_y !== 10'd210 || score_p2 !== 4'd0 || state_dbg !== PLAY)
      $display("FAIL left_hit got %0d,%0d s2=%0d st=%0d want 10,210 s2=0 st=1", ball_x, ball_y, score_p2, state_dbg); else passes++;
    frame();
    checks++; if (ball_x !== 10'd11 || ball_y !== 10'd211) $display("FAIL after_left_hit got %0d,%0d want 11,211", ball_x, ball_y); else passes++;
  endtask

  task automatic test_left_miss();
    do_reset();
    p1_up = 1'b1;
    p2_down = 1'b1;
    frames(88);
    p2_down = 1'b0;
    frames(19);
    checks++; if (p1_y !== 10'd1 || p2_y !== 10'd391) $display("FAIL miss_setup got %0d,%0d want 1,391", p1_y, p2_y); else passes++;
    frame();
    p1_up = 1'b0;
    checks++; if (p1_y !== 10'd0) $display("FAIL p1_one_to_zero got %0d want 0", p1_y); else passes++;
    pulse_serve();
    frame();
    frames(920);
    checks++; if (ball_x !== 10'd9 || ball_y !== 10'd210) $display("FAIL left_pass got %0d,%0d want 9,210", ball_x, ball_y); else passes++;
    frames(9);
    checks++; if (ball_x !== 10'd0 || ball_y !== 10'd219 || state_dbg !== PLAY)
      $display("FAIL left_edge got %0d,%0d st=%0d want 0,219 st=1", ball_x, ball_y, state_dbg); else passes++;
    frame();
    checks++; if (state_dbg !== POINT || score_p2 !== 4'd1 || score_p1 !== 4'd0 || ball_x !== 10'd0 || ball_y !== 10'd220)
      $display("FAIL left_miss got st=%0d s=%0d,%0d %0d,%0d want 2 s=0,1 0,220", state_dbg, score_p1, score_p2, ball_x, ball_y); else passes++;
    frames(59);
    checks++; if (state_dbg !== POINT) $display("FAIL left_point_hold got st=%0d want 2", state_dbg); else passes++;
    frame();
    checks++; if (state_dbg !== IDLE || ball_x !== 10'd316 || ball_y !== 10'd236)
      $display("FAIL left_point_exit got st=%0d %0d,%0d want 0 316,236", state_dbg, ball_x, ball_y); else passes++;
    pulse_serve();
    frames(2);
    checks++; if (ball_x !== 10'd315 || ball_y !== 10'd235) $display("FAIL serve_dir_after_p2 got %0d,%0d want 315,235", ball_x, ball_y); else passes++;
  endtask

  task automatic test_game_over();
    do_reset();
    for (int p = 1; p <= 9; p++) begin
      pulse_serve();
      frames(318);
      checks++; if (state_dbg !== POINT || score_p1 !== 4'(p))
        $display("FAIL rally%0d_point got st=%0d s1=%0d want 2 s1=%0d", p, state_dbg, score_p1, p); else passes++;
      if (p < 9) begin
        frames(60);
        checks++; if (state_dbg !== IDLE) $display("FAIL rally%0d_idle got st=%0d want 0", p, state_dbg); else passes++;
      end
    end
    p1_down = 1'b1;
    frames(59);
    p1_down = 1'b0;
    frame();
    checks++; if (state_dbg !== OVER || game_over !== 1'b1 || score_p1 !== 4'd9 || score_p2 !== 4'd0 || p1_y !== 10'd333)
      $display("FAIL over_enter got st=%0d go=%0d s=%0d,%0d p1=%0d want 3 1 9,0 333", state_dbg, game_over, score_p1, score_p2, p1_y); else passes++;
    p1_down = 1'b1;
    frames(3);
    p1_down = 1'b0;
    checks++; if (p1_y !== 10'd333 || ball_x !== 10'd632 || ball_y !== 10'd392 || score_p1 !== 4'd9)
      $display("FAIL over_frozen got p1=%0d %0d,%0d s1=%0d want 333 632,392 9", p1_y, ball_x, ball_y, score_p1); else passes++;
    pulse_serve();
    checks++; if (state_dbg !== OVER) $display("FAIL over_waits_tick got st=%0d want 3", state_dbg); else passes++;
    frame();
    checks++; if (state_dbg !== IDLE || game_over !== 1'b0 || score_p1 !== 4'd0 || score_p2 !== 4'd0)
      $display("FAIL restart_state got st=%0d go=%0d s=%0d,%0d want 0 0 0,0", state_dbg, game_over, score_p1, score_p2); else passes++;
    checks++; if (p1_y !== 10'd215 || p2_y !== 10'd215 || ball_x !== 10'd316 || ball_y !== 10'd236)
      $display("FAIL restart_pos got p=%0d,%0d %0d,%0d want 215,215 316,236", p1_y, p2_y, ball_x, ball_y); else passes++;
    frame();
    checks++; if (state_dbg !== IDLE) $display("FAIL restart_pending_cleared got st=%0d want 0", state_dbg); else passes++;
  endtask

  initial begin
    test_reset();
    test_paddle_clamp();
    test_serve_and_tick();
    test_wall_and_right_miss();
    test_point_hold();
    test_left_hit();
    test_left_miss();
    test_game_over();
    // final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
